elevator_car_model: RTL and testbench
=====================================

// Module: elevator_car_model
// PURPOSE
//  Behavioural model of the 4-floor elevator car and shaft. It is the plant that the floor
//  controller drives: it consumes the controller's up/down/complete commands and produces
//  what the controller reads: one-hot floor position, door-open status and a HEX floor display.
//  It closes the loop on the DE-board build and in simulation.
// PARAMETERS
//  TRAVEL_CYCLES  50_000_000   clk cycles to move one floor (>=2)
//  DOOR_CYCLES    150_000_000  clk cycles the door stays open with no obstruction (>=2)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  async active-low reset
//  up_i         in   1  controller command: move up
//  down_i       in   1  controller command: move down
//  complete_i   in   1  controller: request floor reached
//  obstruct_i   in   1  door obstruction sensor (1 = blocked)
//  floor_o      out  4  one-hot car position: 0001=F1, 0010=F2, 0100=F3, 1000=F4
//  floor_num_o  out  2  binary position, 0..3 = F1..F4
//  moving_o     out  1  car between floors
//  door_open_o  out  1  door open
//  fault_o      out  1  illegal command, registered
//  hex0_o       out  7  active-low 7-seg, gfedcba, shows floor number
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, floor F1 (floor_o=0001, floor_num_o=0), cnt=0,
//   moving_o=0, door_open_o=0, fault_o=0, hex0_o=7'b1111001. All outputs registered.
//  FSM states: IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN.
//  IDLE: sampled each edge, priority in listed order.
//   up_i&down_i -> stay IDLE.
//   up_i at F4 or down_i at F1 -> stay IDLE.
//   up_i -> MOVE_UP. down_i -> MOVE_DOWN. On the entry edge: cnt=0, moving_o=1.
//   complete_i in IDLE does not open the door. The door opens only via ARRIVE.
//  MOVE_*: cnt increments every cycle. Commands are ignored; a car never stops between floors.
//   At the edge where cnt==TRAVEL_CYCLES-1: floor_num_o +/-1, floor_o shifts left/right one bit,
//   hex0_o updates, moving_o=0, cnt=0, state goes to ARRIVE.
//   Floor changes exactly TRAVEL_CYCLES edges after the entry edge.
//  ARRIVE (1 cycle): complete_i=1 -> DOOR_OPEN (door_open_o=1, cnt=0). Otherwise -> IDLE.
//  DOOR_OPEN: cnt increments. obstruct_i=1 forces cnt=0 on that edge.
//   At cnt==DOOR_CYCLES-1 with obstruct_i=0: door_open_o=0, cnt=0, state goes to IDLE.
//   up_i and down_i are ignored while the door is open.
//  fault_o: registered every edge in every state as
//   (up_i&down_i) | (up_i & F4 & IDLE) | (down_i & F1 & IDLE).
//  floor_o is always exactly one-hot and agrees with floor_num_o. No wrap: F4+1 and F1-1 never occur.
//  cnt is wide enough for max(TRAVEL_CYCLES, DOOR_CYCLES)-1, unsigned, no overflow.
//  Reset asserted mid-move or mid-door: immediate return to reset values.
//   The car snaps to F1 (model simplification).
//  hex0_o encoding: F1=1111001, F2=0100100, F3=0110000, F4=0011001.
// TESTING  (TRAVEL_CYCLES=4, DOOR_CYCLES=6)
//  1 Reset: rst_n=0 then 1 -> floor_o=0001, hex0_o=1111001, door_open_o=0, moving_o=0, fault_o=0.
//  2 up_i=1 held from F1 -> moving_o=1 next edge; floor_o=0010 exactly 4 edges after entry;
//    repeats to F3 and F4; at F4 the car stays, fault_o=1, floor_o=1000.
//  3 At F3, down_i pulse for 1 cycle -> car still reaches F2 (0010) after 4 edges. ARRIVE with
//    complete_i=1 -> door_open_o=1 for 6 cycles, then IDLE.
//  4 Door open, obstruct_i=1 at cycle 4 for 3 cycles -> door_open_o stays 1 until 6 cycles after
//    obstruct_i falls. up_i during the door-open period has no effect.
//  5 up_i=down_i=1 in IDLE at F2 -> fault_o=1 next edge, no motion, floor_o=0010.
//  6 rst_n=0 at cnt=2 of MOVE_UP from F2 -> immediately floor_o=0001, moving_o=0, state IDLE.

Source files
------------

// File: rtl/elevator_car_model_if.sv
// Command/status bundle between the floor controller (master) and the elevator car plant (slave).
// Member names keep the _i/_o suffixes as seen from the car.
interface elevator_car_model_if;
  logic       up_i;
  logic       down_i;
  logic       complete_i;
  logic       obstruct_i;
  logic [3:0] floor_o;
  logic [1:0] floor_num_o;
  logic       moving_o;
  logic       door_open_o;
  logic       fault_o;
  logic [6:0] hex0_o;

  modport master (
    output up_i, down_i, complete_i, obstruct_i,
    input  floor_o, floor_num_o, moving_o, door_open_o, fault_o, hex0_o
  );

  modport slave (
    input  up_i, down_i, complete_i, obstruct_i,
    output floor_o, floor_num_o, moving_o, door_open_o, fault_o, hex0_o
  );
endinterface

// File: rtl/elevator_car_model.sv
// Behavioural plant for a 4-floor elevator car: travels one floor per command, opens its door
// on a completed request and reports position, door state, a HEX display and illegal commands.
module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 150_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  elevator_car_model_if.slave   bus
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN} state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       floor_q,     floor_d;
  logic [1:0]       floor_num_q, floor_num_d;
  logic             moving_q,    moving_d;
  logic             door_open_q, door_open_d;
  logic             fault_q,     fault_d;
  logic [6:0]       hex0_q,      hex0_d;

  function automatic logic [6:0] hex_of(input logic [1:0] num);
    case (num)
      2'd0:    hex_of = 7'b1111001;
      2'd1:    hex_of = 7'b0100100;
      2'd2:    hex_of = 7'b0110000;
      default: hex_of = 7'b0011001;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    floor_d     = floor_q;
    floor_num_d = floor_num_q;
    moving_d    = moving_q;
    door_open_d = door_open_q;
    hex0_d      = hex0_q;
    fault_d     = (bus.up_i & bus.down_i)
                | (bus.up_i   & (floor_num_q == 2'd3) & (state_q == IDLE))
                | (bus.down_i & (floor_num_q == 2'd0) & (state_q == IDLE));

    case (state_q)
      IDLE: begin
        if (bus.up_i && bus.down_i) begin
          state_d = IDLE;
        end else if ((bus.up_i && floor_num_q == 2'd3) || (bus.down_i && floor_num_q == 2'd0)) begin
          state_d = IDLE;
        end else if (bus.up_i || bus.down_i) begin
          state_d  = bus.up_i ? MOVE_UP : MOVE_DOWN;
          cnt_d    = '0;
          moving_d = 1'b1;
        end
      end

      // Commands are not sampled here: once moving, the car always completes the floor.
      MOVE_UP, MOVE_DOWN: begin
        if (cnt_q == TRAVEL_LAST) begin
          if (state_q == MOVE_UP) begin
            floor_num_d = floor_num_q + 2'd1;
            floor_d     = floor_q << 1;
          end else begin
            floor_num_d = floor_num_q - 2'd1;
            floor_d     = floor_q >> 1;
          end
          hex0_d   = hex_of(floor_num_d);
          moving_d = 1'b0;
          cnt_d    = '0;
          state_d  = ARRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ARRIVE: begin
        if (bus.complete_i) begin
          state_d     = DOOR_OPEN;
          door_open_d = 1'b1;
          cnt_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end

      DOOR_OPEN: begin
        if (bus.obstruct_i) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          door_open_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      floor_q     <= 4'b0001;
      floor_num_q <= 2'd0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      fault_q     <= 1'b0;
      hex0_q      <= 7'b1111001;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      floor_q     <= floor_d;
      floor_num_q <= floor_num_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      fault_q     <= fault_d;
      hex0_q      <= hex0_d;
    end
  end

  assign bus.floor_o     = floor_q;
  assign bus.floor_num_o = floor_num_q;
  assign bus.moving_o    = moving_q;
  assign bus.door_open_o = door_open_q;
  assign bus.fault_o     = fault_q;
  assign bus.hex0_o      = hex0_q;

endmodule

// File: tb/tb_elevator_car_model.sv
// Directed bench for elevator_car_model with TRAVEL_CYCLES=4, DOOR_CYCLES=6.
// Outputs are sampled 1 time unit after the rising edge that produced them.
module tb_elevator_car_model;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  localparam logic [6:0] HEX_F1 = 7'b1111001;
  localparam logic [6:0] HEX_F2 = 7'b0100100;
  localparam logic [6:0] HEX_F3 = 7'b0110000;
  localparam logic [6:0] HEX_F4 = 7'b0011001;

  elevator_car_model_if bus ();

  elevator_car_model #(
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input logic [3:0] fl, input logic [1:0] num,
                           input logic [6:0] hex);
    check({tag, ".floor"}, 32'(bus.floor_o), 32'(fl));
    check({tag, ".num"},   32'(bus.floor_num_o), 32'(num));
    check({tag, ".hex"},   32'(bus.hex0_o), 32'(hex));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n          = 1'b0;
    bus.up_i       = 1'b0;
    bus.down_i     = 1'b0;
    bus.complete_i = 1'b0;
    bus.obstruct_i = 1'b0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_pos("reset", 4'b0001, 2'd0, HEX_F1);
    check("reset.moving", 32'(bus.moving_o), 0);
    check("reset.door",   32'(bus.door_open_o), 0);
    check("reset.fault",  32'(bus.fault_o), 0);

    // down at F1 is illegal: fault, no motion
    bus.down_i = 1'b1;
    step();
    check("f1_down.fault",  32'(bus.fault_o), 1);
    check("f1_down.moving", 32'(bus.moving_o), 0);
    bus.down_i = 1'b0;
    step();
    check("f1_down.fault_clr", 32'(bus.fault_o), 0);

    // 2: up held from F1 to F4
    bus.up_i = 1'b1;
    step();
    check("up1.entry_moving", 32'(bus.moving_o), 1);
    step(3);
    check("up1.not_yet", 32'(bus.floor_o), 32'(4'b0001));
    step();
    check_pos("up1.arrive", 4'b0010, 2'd1, HEX_F2);
    check("up1.moving_off", 32'(bus.moving_o), 0);
    step();
    check("up2.arrive_idle", 32'(bus.moving_o), 0);
    step();
    check("up2.entry_moving", 32'(bus.moving_o), 1);
    step(3);
    check("up2.not_yet", 32'(bus.floor_o), 32'(4'b0010));
    step();
    check_pos("up2.arrive", 4'b0100, 2'd2, HEX_F3);
    step(2);
    check("up3.entry_moving", 32'(bus.moving_o), 1);
    step(4);
    check_pos("up3.arrive", 4'b1000, 2'd3, HEX_F4);
    check("up3.fault_arrive", 32'(bus.fault_o), 0);
    step(2);
    check("f4_up.fault",  32'(bus.fault_o), 1);
    check("f4_up.moving", 32'(bus.moving_o), 0);
    check("f4_up.floor",  32'(bus.floor_o), 32'(4'b1000));
    bus.up_i = 1'b0;
    step();
    check("f4_up.fault_clr", 32'(bus.fault_o), 0);

    // F4 -> F3
    bus.down_i = 1'b1;
    step();
    bus.down_i = 1'b0;
    check("down1.entry_moving", 32'(bus.moving_o), 1);
    step(4);
    check_pos("down1.arrive", 4'b0100, 2'd2, HEX_F3);
    step();

    // 3: 1-cycle down pulse at F3 still completes the floor, then door opens
    bus.down_i = 1'b1;
    step();
    bus.down_i = 1'b0;
    step(3);
    check("down2.still_moving", 32'(bus.moving_o), 1);
    check("down2.not_yet", 32'(bus.floor_o), 32'(4'b0100));
    step();
    check_pos("down2.arrive", 4'b0010, 2'd1, HEX_F2);
    bus.complete_i = 1'b1;
    step();
    bus.complete_i = 1'b0;
    check("door1.open", 32'(bus.door_open_o), 1);
    bus.up_i = 1'b1;
    step(2);
    check("door1.up_ignored", 32'(bus.moving_o), 0);
    check("door1.no_fault",   32'(bus.fault_o), 0);
    bus.up_i = 1'b0;
    step(3);
    check("door1.open_c5", 32'(bus.door_open_o), 1);
    step();
    check("door1.closed", 32'(bus.door_open_o), 0);
    check("door1.floor",  32'(bus.floor_o), 32'(4'b0010));

    // 4: F2 -> F3, door open with obstruction at cycle 4 for 3 cycles
    bus.up_i = 1'b1;
    step();
    bus.up_i = 1'b0;
    step(4);
    check_pos("up4.arrive", 4'b0100, 2'd2, HEX_F3);
    bus.complete_i = 1'b1;
    step();
    bus.complete_i = 1'b0;
    check("door2.open", 32'(bus.door_open_o), 1);
    step(3);
    bus.obstruct_i = 1'b1;
    bus.up_i       = 1'b1;
    step(3);
    check("door2.held_by_obstruct", 32'(bus.door_open_o), 1);
    check("door2.up_ignored",       32'(bus.moving_o), 0);
    bus.obstruct_i = 1'b0;
    bus.up_i       = 1'b0;
    step(5);
    check("door2.open_after_5", 32'(bus.door_open_o), 1);
    step();
    check("door2.closed", 32'(bus.door_open_o), 0);
    check("door2.floor",  32'(bus.floor_o), 32'(4'b0100));

    // F3 -> F2
    bus.down_i = 1'b1;
    step();
    bus.down_i = 1'b0;
    step(4);
    check_pos("down3.arrive", 4'b0010, 2'd1, HEX_F2);
    step();

    // 5: up and down together in IDLE at F2
    bus.up_i   = 1'b1;
    bus.down_i = 1'b1;
    step();
    check("both.fault",  32'(bus.fault_o), 1);
    check("both.moving", 32'(bus.moving_o), 0);
    step();
    check("both.floor", 32'(bus.floor_o), 32'(4'b0010));
    check("both.still_idle", 32'(bus.moving_o), 0);
    bus.up_i   = 1'b0;
    bus.down_i = 1'b0;
    step();
    check("both.fault_clr", 32'(bus.fault_o), 0);

    // 6: reset mid-move (cnt=2 of MOVE_UP from F2)
    bus.up_i = 1'b1;
    step();
    bus.up_i = 1'b0;
    step(2);
    check("mid.moving", 32'(bus.moving_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_pos("mid_rst", 4'b0001, 2'd0, HEX_F1);
    check("mid_rst.moving", 32'(bus.moving_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.up_i = 1'b1;
    step();
    bus.up_i = 1'b0;
    check("post_rst.idle_accepts_up", 32'(bus.moving_o), 1);
    step(4);
    check_pos("post_rst.arrive", 4'b0010, 2'd1, HEX_F2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
